// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcodes, step encoding and control-word layout shared by the sequencer
package control_sequencer_pkg;
  localparam int MEM_WAIT_DEFAULT = 0;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011,
                         OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHL = 5'b00110, OP_ROR = 5'b00111,
                         OP_ROL = 5'b01000, OP_AND = 5'b01001, OP_OR = 5'b01010, OP_ADDI = 5'b01011,
                         OP_ANDI = 5'b01100, OP_ORI = 5'b01101, OP_MUL = 5'b01110, OP_DIV = 5'b01111,
                         OP_NEG = 5'b10000, OP_NOT = 5'b10001, OP_BRX = 5'b10010, OP_JR = 5'b10011,
                         OP_JAL = 5'b10100, OP_IN = 5'b10101, OP_OUT = 5'b10110, OP_MFHI = 5'b10111,
                         OP_MFLO = 5'b11000, OP_NOP = 5'b11001, OP_HALT = 5'b11010;
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;
  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MD, CL_UN, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } op_class_t;
  typedef struct packed {
    logic [4:0] alu;
    logic inc_pc, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, read, write;
    logic gra, grb, grc, r_in, r_out, ba_out, c_out, r15sel;
    logic hi_in, lo_in, hi_out, lo_out, inport_out, outport_in, con_in;
  } cw_t;
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: return CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: return CL_IMM;
      OP_LD: return CL_LD;
      OP_LDI: return CL_LDI;
      OP_ST: return CL_ST;
      OP_MUL, OP_DIV: return CL_MD;
      OP_NEG, OP_NOT: return CL_UN;
      OP_BRX: return CL_BR;
      OP_JR: return CL_JR;
      OP_JAL: return CL_JAL;
      OP_IN: return CL_IN;
      OP_OUT: return CL_OUT;
      OP_MFHI: return CL_MFHI;
      OP_MFLO: return CL_MFLO;
      OP_HALT: return CL_HALT;
      OP_NOP: return CL_NOP;
      default: return CL_NOP;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer_step_decoder.sv
// control_sequencer_step_decoder: (opcode, step, CON_FF) -> control word and last-step flag
module control_sequencer_step_decoder
  import control_sequencer_pkg::*;
(
  input  step_t      step,
  input  logic [4:0] op,
  input  logic       con_ff,
  output cw_t        cw,
  output logic       last
);
  op_class_t cls;
  assign cls = op_class(op);
  always_comb begin
    cw = '0;
    last = 1'b0;
    case (step)
      T0: {cw.pc_out, cw.mar_in, cw.inc_pc, cw.z_in} = 4'hf;
      T1: {cw.zlow_out, cw.pc_in, cw.read, cw.mdr_in} = 4'hf;
      T2: begin
        {cw.mdr_out, cw.ir_in} = 2'b11;
        last = cls inside {CL_NOP, CL_HALT};
      end
      T3: case (cls)
        CL_ALU, CL_IMM: {cw.grb, cw.r_out, cw.y_in} = 3'b111;
        CL_LD, CL_LDI, CL_ST: {cw.grb, cw.ba_out, cw.y_in} = 3'b111;
        CL_MD: {cw.gra, cw.r_out, cw.y_in} = 3'b111;
        CL_UN: begin
          {cw.grb, cw.r_out, cw.z_in} = 3'b111;
          cw.alu = op;
        end
        CL_BR: {cw.gra, cw.r_out, cw.con_in} = 3'b111;
        CL_JR: {cw.gra, cw.r_out, cw.pc_in, last} = 4'hf;
        CL_JAL: {cw.pc_out, cw.r15sel, cw.r_in} = 3'b111;
        CL_IN: {cw.inport_out, cw.gra, cw.r_in, last} = 4'hf;
        CL_OUT: {cw.gra, cw.r_out, cw.outport_in, last} = 4'hf;
        CL_MFHI: {cw.hi_out, cw.gra, cw.r_in, last} = 4'hf;
        CL_MFLO: {cw.lo_out, cw.gra, cw.r_in, last} = 4'hf;
        default: ;
      endcase
      T4: case (cls)
        CL_ALU: begin
          {cw.grc, cw.r_out, cw.z_in} = 3'b111;
          cw.alu = op;
        end
        CL_IMM: begin
          {cw.c_out, cw.z_in} = 2'b11;
          cw.alu = op;
        end
        CL_LD, CL_LDI, CL_ST: begin
          {cw.c_out, cw.z_in} = 2'b11;
          cw.alu = OP_ADD;
        end
        CL_MD: begin
          {cw.grb, cw.r_out, cw.z_in} = 3'b111;
          cw.alu = op;
        end
        CL_UN: {cw.zlow_out, cw.gra, cw.r_in, last} = 4'hf;
        CL_BR: {cw.pc_out, cw.y_in} = 2'b11;
        CL_JAL: {cw.gra, cw.r_out, cw.pc_in, last} = 4'hf;
        default: ;
      endcase
      T5: case (cls)
        CL_ALU, CL_IMM, CL_LDI: {cw.zlow_out, cw.gra, cw.r_in, last} = 4'hf;
        CL_LD, CL_ST: {cw.zlow_out, cw.mar_in} = 2'b11;
        CL_MD: {cw.zlow_out, cw.lo_in} = 2'b11;
        CL_BR: begin
          {cw.c_out, cw.z_in} = 2'b11;
          cw.alu = OP_ADD;
        end
        default: ;
      endcase
      T6: case (cls)
        CL_LD: {cw.read, cw.mdr_in} = 2'b11;
        CL_ST: {cw.gra, cw.r_out, cw.mdr_in} = 3'b111;
        CL_MD: {cw.zhigh_out, cw.hi_in, last} = 3'b111;
        CL_BR: {cw.zlow_out, cw.pc_in, last} = {1'b1, con_ff, 1'b1};
        default: ;
      endcase
      T7: case (cls)
        CL_LD: {cw.mdr_out, cw.gra, cw.r_in, last} = 4'hf;
        CL_ST: {cw.write, last} = 2'b11;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute step sequencer for the single-bus datapath
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  ALU_ctl,
  output logic        IncPC,
  output logic        PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15sel,
  output logic        HIin, LOin, HIout, LOout, InPortout, OutPortin, CONin
);
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT);
  step_t step, step_nx;
  logic [7:0] cnt, cnt_nx;
  logic [4:0] op;
  logic last, hold, unused_ir;
  cw_t cw, ctl;
  assign op = IR[31:27];
  assign unused_ir = ^IR[26:0];
  control_sequencer_step_decoder dec (.step(step), .op(op), .con_ff(CON_FF), .cw(cw), .last(last));
  // memory steps stay put until the wait counter reaches MEM_WAIT
  assign hold = (cw.read | cw.write) && cnt != WAIT_MAX;
  always_comb begin
    cnt_nx = hold ? cnt + 8'd1 : 8'd0;
    step_nx = step == HALT ? HALT
            : hold ? step
            : last ? ((Stop || op == OP_HALT) ? HALT : T0)
            : step_t'(step + 4'd1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      step <= T0;
      cnt <= 8'd0;
    end else begin
      step <= step_nx;
      cnt <= cnt_nx;
    end
  assign ctl = reset ? '0 : cw;
  assign Run = step != HALT;
  assign {ALU_ctl, IncPC, PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, Read, Write,
          Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15sel,
          HIin, LOin, HIout, LOout, InPortout, OutPortin, CONin} = ctl;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of the control words on MEM_WAIT=0 and MEM_WAIT=2 instances
module tb_control_sequencer;
  import control_sequencer_pkg::*;
  localparam logic H = 1'b1;
  localparam cw_t Z    = '0;
  localparam cw_t W_T0 = '{pc_out:H, mar_in:H, inc_pc:H, z_in:H, default:'0};
  localparam cw_t W_T1 = '{zlow_out:H, pc_in:H, read:H, mdr_in:H, default:'0};
  localparam cw_t W_T2 = '{mdr_out:H, ir_in:H, default:'0};
  localparam cw_t W_RB = '{grb:H, r_out:H, y_in:H, default:'0};
  localparam cw_t W_WR = '{zlow_out:H, gra:H, r_in:H, default:'0};
  localparam cw_t W_BA = '{grb:H, ba_out:H, y_in:H, default:'0};
  localparam cw_t W_CA = '{c_out:H, z_in:H, alu:5'b00011, default:'0};
  localparam cw_t W_ZM = '{zlow_out:H, mar_in:H, default:'0};
  logic clock = 1'b0;
  logic rst_v [2];
  logic [31:0] ir;
  logic con_ff, stop;
  cw_t act_v [2];
  logic run_v [2];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 2; g++) begin : u
    logic Run, IncPC, PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15sel, HIin, LOin, HIout, LOout, InPortout, OutPortin, CONin;
    logic [4:0] ALU_ctl;
    control_sequencer #(.MEM_WAIT(2 * g)) dut (
      .clock(clock), .reset(rst_v[g]), .IR(ir), .CON_FF(con_ff), .Stop(stop), .Run(Run),
      .ALU_ctl(ALU_ctl), .IncPC(IncPC), .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .Cout(Cout), .R15sel(R15sel), .HIin(HIin), .LOin(LOin), .HIout(HIout),
      .LOout(LOout), .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin)
    );
    assign act_v[g] = '{alu:ALU_ctl, inc_pc:IncPC, pc_out:PCout, pc_in:PCin, mar_in:MARin, mdr_in:MDRin,
                        mdr_out:MDRout, ir_in:IRin, y_in:Yin, z_in:Zin, zlow_out:Zlowout, zhigh_out:Zhighout,
                        read:Read, write:Write, gra:Gra, grb:Grb, grc:Grc, r_in:Rin, r_out:Rout,
                        ba_out:BAout, c_out:Cout, r15sel:R15sel, hi_in:HIin, lo_in:LOin, hi_out:HIout,
                        lo_out:LOout, inport_out:InPortout, outport_in:OutPortin, con_in:CONin};
    assign run_v[g] = Run;
  end
  task automatic chk(input int g, input string tag, input cw_t e, input logic r);
    checks++;
    assert ({run_v[g], act_v[g]} === {r, e}) else begin
      errors++;
      $error("FAIL %s: run=%b cw=%h, expected run=%b cw=%h", tag, run_v[g], act_v[g], r, e);
    end
  endtask
  task automatic tick(input int g, input string tag, input cw_t e, input logic r = 1'b1);
    @(negedge clock);
    chk(g, tag, e, r);
  endtask
  task automatic fetch(input int g, input string tag);
    for (int i = 0; i <= 2 * g; i++) tick(g, {tag, "_t1"}, W_T1);
    tick(g, {tag, "_t2"}, W_T2);
  endtask
  task automatic restart(input int g, input logic [4:0] op, input string tag);
    rst_v[g] = 1'b1;
    #1 chk(g, {tag, "_rst"}, Z, 1'b1);
    @(negedge clock);
    rst_v[g] = 1'b0;
    ir = {op, 27'h2ABCDEF};
    #1 chk(g, {tag, "_t0"}, W_T0, 1'b1);
  endtask
  initial begin
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    ir = {OP_ADD, 27'h2ABCDEF};
    con_ff = 1'b0;
    stop = 1'b0;
    #12 chk(0, "reset", Z, 1'b1);
    @(negedge clock);
    rst_v[0] = 1'b0;
    #1 chk(0, "add_t0", W_T0, 1'b1);
    fetch(0, "add");
    tick(0, "add_t3", W_RB);
    tick(0, "add_t4", '{grc:H, r_out:H, z_in:H, alu:OP_ADD, default:'0});
    tick(0, "add_t5", W_WR);
    tick(0, "add_next", W_T0);
    // abort an add in the middle of T4
    fetch(0, "add2");
    tick(0, "add2_t3", W_RB);
    tick(0, "add2_t4", '{grc:H, r_out:H, z_in:H, alu:OP_ADD, default:'0});
    restart(0, OP_BRX, "abort");
    fetch(0, "brx0");
    tick(0, "brx0_t3", '{gra:H, r_out:H, con_in:H, default:'0});
    tick(0, "brx0_t4", '{pc_out:H, y_in:H, default:'0});
    tick(0, "brx0_t5", W_CA);
    tick(0, "brx0_t6", '{zlow_out:H, default:'0});
    tick(0, "brx0_next", W_T0);
    con_ff = 1'b1;
    fetch(0, "brx1");
    tick(0, "brx1_t3", '{gra:H, r_out:H, con_in:H, default:'0});
    tick(0, "brx1_t4", '{pc_out:H, y_in:H, default:'0});
    tick(0, "brx1_t5", W_CA);
    tick(0, "brx1_t6", '{zlow_out:H, pc_in:H, default:'0});
    tick(0, "brx1_next", W_T0);
    ir = {OP_MUL, 27'h2ABCDEF};
    fetch(0, "mul");
    tick(0, "mul_t3", '{gra:H, r_out:H, y_in:H, default:'0});
    tick(0, "mul_t4", '{grb:H, r_out:H, z_in:H, alu:OP_MUL, default:'0});
    tick(0, "mul_t5", '{zlow_out:H, lo_in:H, default:'0});
    tick(0, "mul_t6", '{zhigh_out:H, hi_in:H, default:'0});
    tick(0, "mul_next", W_T0);
    ir = {OP_NEG, 27'h2ABCDEF};
    fetch(0, "neg");
    tick(0, "neg_t3", '{grb:H, r_out:H, z_in:H, alu:OP_NEG, default:'0});
    tick(0, "neg_t4", W_WR);
    tick(0, "neg_next", W_T0);
    // Stop raised mid-instruction only takes effect at the boundary
    ir = {OP_SUB, 27'h2ABCDEF};
    fetch(0, "sub");
    tick(0, "sub_t3", W_RB);
    tick(0, "sub_t4", '{grc:H, r_out:H, z_in:H, alu:OP_SUB, default:'0});
    stop = 1'b1;
    tick(0, "sub_t5", W_WR);
    tick(0, "sub_halt", Z, 1'b0);
    stop = 1'b0;
    tick(0, "sub_halt_hold1", Z, 1'b0);
    tick(0, "sub_halt_hold2", Z, 1'b0);
    restart(0, OP_HALT, "hlt");
    fetch(0, "hlt");
    tick(0, "hlt_halt", Z, 1'b0);
    tick(0, "hlt_hold", Z, 1'b0);
    restart(0, OP_NOP, "nop");
    fetch(0, "nop");
    tick(0, "nop_next", W_T0);
    ir = {5'b11111, 27'h2ABCDEF};
    fetch(0, "undef");
    tick(0, "undef_next", W_T0);
    rst_v[0] = 1'b1;
    // MEM_WAIT=2 instance: ld and a st aborted during its Write
    restart(1, OP_LD, "ld");
    fetch(1, "ld");
    tick(1, "ld_t3", W_BA);
    tick(1, "ld_t4", W_CA);
    tick(1, "ld_t5", W_ZM);
    for (int i = 0; i < 3; i++) tick(1, "ld_t6", '{read:H, mdr_in:H, default:'0});
    tick(1, "ld_t7", '{mdr_out:H, gra:H, r_in:H, default:'0});
    tick(1, "ld_next", W_T0);
    ir = {OP_ST, 27'h2ABCDEF};
    fetch(1, "st");
    tick(1, "st_t3", W_BA);
    tick(1, "st_t4", W_CA);
    tick(1, "st_t5", W_ZM);
    tick(1, "st_t6", '{gra:H, r_out:H, mdr_in:H, default:'0});
    tick(1, "st_t7", '{write:H, default:'0});
    restart(1, OP_ST, "st_abort");
    tick(1, "st_abort_t1", W_T1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
